// File: rtl/line_clear_ctrl_if.sv
// rtl/line_clear_ctrl_if.sv - row RAM port bundle between the line-clear sequencer and the board memory
interface line_clear_ctrl_if #(
  parameter int AW   = 5,
  parameter int COLS = 10
);
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - flashes full rows, compacts the board bottom-up and zero-fills the top
module line_clear_ctrl #(
  parameter int ROWS         = 20,
  parameter int COLS         = 10,
  parameter int FLASH_CYCLES = 30000000,
  parameter int AW           = $clog2(ROWS),
  parameter int CW           = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ROWS-1:0] row_full,
  output logic            busy,
  output logic            flashing,
  output logic [ROWS-1:0] flash_mask,
  output logic            done,
  output logic [CW-1:0]   lines_cleared,
  line_clear_ctrl_if.master ram
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLASH = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int            TW         = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(FLASH_CYCLES - 1);
  localparam logic [AW-1:0] ROW_LAST   = AW'(ROWS - 1);

  logic [2:0]      state_q, state_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   lines_q, lines_d;

  logic            rd_en, wr_en;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [COLS-1:0] wr_data;
  logic            row_is_full;
  logic [CW-1:0]   cnt_inc;

  assign row_is_full = mask_q[src_q];
  assign cnt_inc     = cnt_q + CW'(row_is_full);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    lines_d = lines_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = row_full;
          src_d   = ROW_LAST;
          dst_d   = ROW_LAST;
          cnt_d   = '0;
          fill_d  = '0;
          timer_d = '0;
          if (row_full == '0) begin
            state_d = S_DONE;
            lines_d = '0;
          end else begin
            state_d = S_FLASH;
          end
        end
      end

      S_FLASH: begin
        if (timer_q == TIMER_LAST) begin
          state_d = S_READ;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = src_q;
        state_d = S_EVAL;
      end

      S_EVAL: begin
        cnt_d = cnt_inc;
        // A surviving row already at its final position needs no write.
        if (!row_is_full) begin
          if (dst_q != src_q) begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            wr_data = ram.rd_data;
          end
          if (dst_q != '0) begin
            dst_d = dst_q - AW'(1);
          end
        end
        if (src_q == '0) begin
          if (cnt_inc == '0) begin
            state_d = S_DONE;
            lines_d = '0;
          end else begin
            state_d = S_FILL;
            fill_d  = '0;
          end
        end else begin
          src_d   = src_q - AW'(1);
          state_d = S_READ;
        end
      end

      S_FILL: begin
        wr_en   = 1'b1;
        wr_addr = fill_q;
        if (CW'(fill_q) + CW'(1) == cnt_q) begin
          state_d = S_DONE;
          lines_d = cnt_q;
        end else begin
          fill_d = fill_q + AW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      lines_q <= lines_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign flashing      = (state_q == S_FLASH);
  assign done          = (state_q == S_DONE);
  assign flash_mask    = busy ? mask_q : '0;
  assign lines_cleared = lines_q;

  assign ram.rd_en   = rd_en;
  assign ram.rd_addr = rd_addr;
  assign ram.wr_en   = wr_en;
  assign ram.wr_addr = wr_addr;
  assign ram.wr_data = wr_data;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - directed self-checking bench for line_clear_ctrl with a behavioural row RAM
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int FC   = 4;
  localparam int AW   = 5;
  localparam int CW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [ROWS-1:0] row_full = '0;
  logic            busy, flashing, done;
  logic [ROWS-1:0] flash_mask;
  logic [CW-1:0]   lines_cleared;

  line_clear_ctrl_if #(.AW(AW), .COLS(COLS)) ram_if ();

  line_clear_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .FLASH_CYCLES(FC), .AW(AW), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .row_full(row_full),
    .busy(busy),
    .flashing(flashing),
    .flash_mask(flash_mask),
    .done(done),
    .lines_cleared(lines_cleared),
    .ram(ram_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic            ld_en = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [COLS-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ram_if.wr_en) mem[ram_if.wr_addr] <= ram_if.wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
    if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];
  end

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, same_cnt = 0;
  int done_cnt = 0, flash_cnt = 0, busy_cnt = 0;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (ram_if.rd_en) rd_cnt <= rd_cnt + 1;
    if (ram_if.wr_en) wr_cnt <= wr_cnt + 1;
    if (ram_if.rd_en && ram_if.wr_en) both_cnt <= both_cnt + 1;
    if (ram_if.wr_en && prev_rd && ram_if.wr_addr == prev_addr) same_cnt <= same_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (flashing) flash_cnt <= flash_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    prev_rd   <= ram_if.rd_en;
    prev_addr <= ram_if.rd_addr;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, busy, flashing, done, ram_if.rd_en, ram_if.wr_en}, 32'd0);
    chk({tag, "_mask"}, 32'(flash_mask), 32'd0);
    chk({tag, "_addr"}, {22'd0, ram_if.rd_addr, ram_if.wr_addr}, 32'd0);
    chk({tag, "_wdata"}, 32'(ram_if.wr_data), 32'd0);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'd0);
  endtask

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = AW'(r);
      ld_data = COLS'(r * 37 + 5);
      img[r]  = COLS'(r * 37 + 5);
    end
    @(negedge clk);
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [ROWS-1:0] m, input bit inject,
                        input int exp_lat, input int exp_lines, input int exp_wr);
    int t0, lat, k, exp_dst;
    int s_rd, s_wr, s_both, s_same, s_done, s_flash, s_busy;
    bit got;
    logic [COLS-1:0] exp_board [ROWS];
    s_rd = rd_cnt; s_wr = wr_cnt; s_both = both_cnt; s_same = same_cnt;
    s_done = done_cnt; s_flash = flash_cnt; s_busy = busy_cnt;
    @(negedge clk);
    row_full = m;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    lat   = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      k = cyc - t0;
      if (done) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (inject) begin
          row_full = ~m;
          start    = (k == 2 || k == 6);
          if (k == 3) chk({tag, "_mask_hold"}, 32'(flash_mask), 32'(m));
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_lines_hold"}, 32'(lines_cleared), 32'(exp_lines));
    repeat (8) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - s_done), 32'd1);
    chk({tag, "_flash_cycles"}, 32'(flash_cnt - s_flash), (m == '0) ? 32'd0 : 32'(FC));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - s_busy), 32'(exp_lat));
    chk({tag, "_reads"}, 32'(rd_cnt - s_rd), (m == '0) ? 32'd0 : 32'(ROWS));
    chk({tag, "_writes"}, 32'(wr_cnt - s_wr), 32'(exp_wr));
    chk({tag, "_rd_wr_overlap"}, 32'(both_cnt - s_both), 32'd0);
    chk({tag, "_self_write"}, 32'(same_cnt - s_same), 32'd0);
    exp_dst = ROWS - 1;
    for (int r = 0; r < ROWS; r++) exp_board[r] = '0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      if (!m[s]) begin
        exp_board[exp_dst] = img[s];
        exp_dst--;
      end
    end
    for (int r = 0; r < ROWS; r++) chk($sformatf("%s_row%0d", tag, r), 32'(mem[r]), 32'(exp_board[r]));
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    load_board();

    run_op("empty", 20'h00000, 1'b0, 1, 0, 0);

    load_board();
    run_op("row19", 20'h80000, 1'b0, 1 + FC + 2 * ROWS + 1, 1, 20);

    load_board();
    run_op("four", 20'hB4000, 1'b0, 1 + FC + 2 * ROWS + 4, 4, 20);

    load_board();
    run_op("row5", 20'h00020, 1'b0, 1 + FC + 2 * ROWS + 1, 1, 6);

    load_board();
    run_op("inject", 20'h80001, 1'b1, 1 + FC + 2 * ROWS + 2, 2, 20);

    // Reset lands while row 12 is being read.
    load_board();
    @(negedge clk);
    row_full = 20'h80000;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && (cyc - t0) < 19; i++) @(negedge clk);
    chk("midreset_at_read", {31'd0, ram_if.rd_en}, 32'd1);
    chk("midreset_rd_addr", 32'(ram_if.rd_addr), 32'd12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_outputs_zero("midreset");
    img = mem;
    run_op("after_reset", 20'h00000, 1'b0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
